endop_monitor: RTL and testbench

- Synthesizable completion monitor for the four-core multiplier processor.
- Watches the four cores' 8-bit instruction buses and latches, per core, the cycle at which the ENDOP opcode (122) first appears.
- Asserts a held `all_done` flag once every core has finished and a settle window has elapsed.
- It is the on-chip consumer of the cores' instruction-stream outputs. It replaces simulation-only end detection and gives the host or top level a done/ack handshake plus per-core cycle counts.

---
 rtl/endop_monitor.sv | 137 +++++++++++++
 tb/tb_endop_monitor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/endop_monitor.sv
// endop_monitor: completion monitor for the four-core multiplier processor.
// Watches the four instruction buses, records per core the run cycle at which
// the ENDOP opcode first appears, and raises a held all_done flag once every
// core has finished and the settle window has elapsed.
//
// Handshake: start is sampled only in IDLE and launches a run; all_done stays
// high in DONE until done_ack is sampled high at an edge, which returns the
// block to IDLE (done_ack wins over start in DONE). Results stay readable in
// IDLE until the next accepted start.
module endop_monitor #(
    parameter int                     INS_WIDTH     = 8,
    parameter logic [INS_WIDTH-1:0]   ENDOP_CODE    = INS_WIDTH'(122),
    parameter int                     SETTLE_CYCLES = 5,
    parameter int                     CNT_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  done_ack,
    input  logic [INS_WIDTH-1:0]  ins1,
    input  logic [INS_WIDTH-1:0]  ins2,
    input  logic [INS_WIDTH-1:0]  ins3,
    input  logic [INS_WIDTH-1:0]  ins4,
    output logic                  busy,
    output logic                  all_done,
    output logic [3:0]            core_done,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [CNT_WIDTH-1:0]  finish1,
    output logic [CNT_WIDTH-1:0]  finish2,
    output logic [CNT_WIDTH-1:0]  finish3,
    output logic [CNT_WIDTH-1:0]  finish4,
    output logic                  overflow,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Settle counter only has to reach SETTLE_CYCLES-1.
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST =
        SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_PRE = {{(CNT_WIDTH-1){1'b1}}, 1'b0};

    state_t          state;
    state_t          state_next;
    logic [SW-1:0]   settle_cnt;
    logic [3:0]      hit;
    logic            all_set;

    assign fsm_state = state;

    // Next-state decode plus the per-core "first ENDOP this edge" vector.
    always_comb begin
        state_next = state;
        hit        = '0;
        all_set    = 1'b0;
        hit[0]     = (ins1 == ENDOP_CODE) && !core_done[0];
        hit[1]     = (ins2 == ENDOP_CODE) && !core_done[1];
        hit[2]     = (ins3 == ENDOP_CODE) && !core_done[2];
        hit[3]     = (ins4 == ENDOP_CODE) && !core_done[3];
        all_set    = &(core_done | hit);
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (all_set) state_next = (SETTLE_CYCLES == 0) ? DONE : SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_next = DONE;
            DONE:    if (done_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register with registered busy/all_done decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            all_done <= 1'b0;
        end else begin
            state    <= state_next;
            busy     <= (state_next == RUN) || (state_next == SETTLE);
            all_done <= (state_next == DONE);
        end
    end

    // Run datapath: cycle counter, per-core capture, overflow and settle count.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_done   <= '0;
            cycle_count <= '0;
            finish1     <= '0;
            finish2     <= '0;
            finish3     <= '0;
            finish4     <= '0;
            overflow    <= 1'b0;
            settle_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        core_done   <= '0;
                        cycle_count <= '0;
                        finish1     <= '0;
                        finish2     <= '0;
                        finish3     <= '0;
                        finish4     <= '0;
                        overflow    <= 1'b0;
                    end
                end
                RUN: begin
                    core_done  <= core_done | hit;
                    settle_cnt <= '0;
                    if (hit[0]) finish1 <= cycle_count;
                    if (hit[1]) finish2 <= cycle_count;
                    if (hit[2]) finish3 <= cycle_count;
                    if (hit[3]) finish4 <= cycle_count;
                    // The finishing edge does not count, so the final count is
                    // the latest capture.
                    if (!all_set && (cycle_count != CNT_MAX)) begin
                        cycle_count <= cycle_count + 1'b1;
                        if (cycle_count == CNT_PRE) overflow <= 1'b1;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_endop_monitor.sv
// tb_endop_monitor: drives two monitors from the same buses (settle 5 with a
// 32-bit counter, settle 0 with a 4-bit counter) and checks both every cycle
// against a run-level model, plus directed scenarios with literal results.
module tb_endop_monitor;

    logic       clk = 1'b0;
    logic       rst, start, done_ack;
    logic [7:0] ins1, ins2, ins3, ins4;

    logic        d0_busy, d0_all_done, d0_overflow;
    logic [3:0]  d0_core_done;
    logic [31:0] d0_cycle, d0_f1, d0_f2, d0_f3, d0_f4;
    logic [1:0]  d0_state;
    logic        d1_busy, d1_all_done, d1_overflow;
    logic [3:0]  d1_core_done;
    logic [3:0]  d1_cycle, d1_f1, d1_f2, d1_f3, d1_f4;
    logic [1:0]  d1_state;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // Clock generation.
    always #5 clk = ~clk;

    endop_monitor #(.SETTLE_CYCLES(5), .CNT_WIDTH(32)) dut0 (
        .clk(clk), .rst(rst), .start(start), .done_ack(done_ack),
        .ins1(ins1), .ins2(ins2), .ins3(ins3), .ins4(ins4),
        .busy(d0_busy), .all_done(d0_all_done), .core_done(d0_core_done),
        .cycle_count(d0_cycle), .finish1(d0_f1), .finish2(d0_f2),
        .finish3(d0_f3), .finish4(d0_f4), .overflow(d0_overflow),
        .fsm_state(d0_state));

    endop_monitor #(.SETTLE_CYCLES(0), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .start(start), .done_ack(done_ack),
        .ins1(ins1), .ins2(ins2), .ins3(ins3), .ins4(ins4),
        .busy(d1_busy), .all_done(d1_all_done), .core_done(d1_core_done),
        .cycle_count(d1_cycle), .finish1(d1_f1), .finish2(d1_f2),
        .finish3(d1_f3), .finish4(d1_f4), .overflow(d1_overflow),
        .fsm_state(d1_state));

    // ---------------- run-level reference model ----------------
    // A run is "active" from accepted start to ack; "complete" once all cores
    // have shown ENDOP; "since" counts edges after completion; "edges" counts
    // the RUN edges on which the counter tried to advance.
    logic       m_active[2];
    logic       m_complete[2];
    int         m_since[2];
    longint     m_edges[2];
    longint     m_fin[2][4];
    logic [3:0] m_seen[2];
    longint     m_max[2]    = '{64'd4294967295, 64'd15};
    int         m_settle[2] = '{5, 0};

    function automatic longint sat(int m, longint v);
        return (v > m_max[m]) ? m_max[m] : v;
    endfunction

    task automatic model_step(int m);
        logic [7:0] b[4];
        b[0] = ins1; b[1] = ins2; b[2] = ins3; b[3] = ins4;
        if (rst) begin
            m_active[m] = 1'b0; m_complete[m] = 1'b0; m_since[m] = 0;
            m_edges[m] = 0; m_seen[m] = 4'h0;
            for (int k = 0; k < 4; k++) m_fin[m][k] = 0;
        end else if (!m_active[m]) begin
            if (start) begin
                m_active[m] = 1'b1; m_complete[m] = 1'b0; m_since[m] = 0;
                m_edges[m] = 0; m_seen[m] = 4'h0;
                for (int k = 0; k < 4; k++) m_fin[m][k] = 0;
            end
        end else if (!m_complete[m]) begin
            for (int k = 0; k < 4; k++)
                if (b[k] == 8'd122 && !m_seen[m][k]) begin
                    m_seen[m][k] = 1'b1;
                    m_fin[m][k]  = m_edges[m];
                end
            if (m_seen[m] == 4'hF) begin
                m_complete[m] = 1'b1;
                m_since[m]    = 0;
            end else begin
                m_edges[m]++;
            end
        end else if (m_since[m] >= m_settle[m]) begin
            if (done_ack) m_active[m] = 1'b0;
        end else begin
            m_since[m]++;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model(int m);
        logic       e_done;
        longint     a[10];
        string      p;
        e_done = m_active[m] && m_complete[m] && (m_since[m] >= m_settle[m]);
        p = (m == 0) ? "d0" : "d1";
        if (m == 0) begin
            a = '{d0_busy, d0_all_done, d0_core_done, d0_cycle, d0_f1, d0_f2,
                  d0_f3, d0_f4, d0_overflow, 0};
        end else begin
            a = '{d1_busy, d1_all_done, d1_core_done, d1_cycle, d1_f1, d1_f2,
                  d1_f3, d1_f4, d1_overflow, 0};
        end
        check({p, ".busy"},      a[0], longint'(m_active[m] && !e_done));
        check({p, ".all_done"},  a[1], longint'(e_done));
        check({p, ".core_done"}, a[2], longint'(m_seen[m]));
        check({p, ".cycle"},     a[3], sat(m, m_edges[m]));
        for (int k = 0; k < 4; k++)
            check($sformatf("%s.finish%0d", p, k + 1), a[4 + k], sat(m, m_fin[m][k]));
        check({p, ".overflow"},  a[8], longint'(m_edges[m] >= m_max[m]));
    endtask

    // Per-cycle compare away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            compare_model(0);
            compare_model(1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ins(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
        ins1 = a; ins2 = b; ins3 = c; ins4 = d;
    endtask

    task automatic start_run();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic ack_run();
        done_ack = 1'b1; tick(); done_ack = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; start = 1'b0; done_ack = 1'b0;
        set_ins(8'd0, 8'd0, 8'd0, 8'd0);
        tick(2);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset busy", d0_busy, 0);
        check("reset core_done", d0_core_done, 0);
        check("reset cycle", d0_cycle, 0);

        // ENDOP while idle is ignored.
        set_ins(8'd122, 8'd122, 8'd122, 8'd122);
        tick(3);
        check("idle endop core_done", d0_core_done, 0);

        // Staggered finish: cores finish on RUN edges 3/7/7/12.
        set_ins(8'd0, 8'd0, 8'd0, 8'd0);
        start_run();
        for (int e = 0; e <= 12; e++) begin
            set_ins((e == 3) ? 8'd122 : 8'd7, (e == 7) ? 8'd122 : 8'd9,
                    (e == 7) ? 8'd122 : 8'd1, (e == 12) ? 8'd122 : 8'd3);
            tick();
        end
        check("stag finish1", d0_f1, 3);
        check("stag finish2", d0_f2, 7);
        check("stag finish3", d0_f3, 7);
        check("stag finish4", d0_f4, 12);
        check("stag cycle", d0_cycle, 12);
        check("stag core_done", d0_core_done, 15);
        check("stag d1 all_done now", d1_all_done, 1);
        set_ins(8'd0, 8'd0, 8'd0, 8'd0);
        tick(4);
        check("stag all_done before window", d0_all_done, 0);
        tick();
        check("stag all_done after window", d0_all_done, 1);

        // Handshake: start together with ack -> ack wins.
        start = 1'b1; done_ack = 1'b1; tick();
        start = 1'b0; done_ack = 1'b0;
        check("hs all_done dropped", d0_all_done, 0);
        check("hs no new run", d0_busy, 0);
        check("hs results held", d0_core_done, 15);
        start_run();
        check("hs new run core_done", d0_core_done, 0);
        check("hs new run cycle", d0_cycle, 0);
        check("hs new run busy", d0_busy, 1);

        // Reset mid-run with two cores done.
        set_ins(8'd122, 8'd122, 8'd0, 8'd0);
        tick();
        check("mid core_done", d0_core_done, 3);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid rst core_done", d0_core_done, 0);
        check("mid rst finish1", d0_f1, 0);
        check("mid rst busy", d0_busy, 0);
        set_ins(8'd122, 8'd122, 8'd122, 8'd122);
        tick(3);
        check("post rst endop ignored", d0_core_done, 0);

        // Saturation on the 4-bit instance.
        set_ins(8'd0, 8'd0, 8'd0, 8'd0);
        start_run();
        tick(20);
        check("sat d1 cycle", d1_cycle, 15);
        check("sat d1 overflow", d1_overflow, 1);
        check("sat d0 cycle", d0_cycle, 20);
        check("sat d0 overflow", d0_overflow, 0);
        set_ins(8'd122, 8'd122, 8'd122, 8'd122);
        tick();
        check("sat d1 finish1", d1_f1, 15);
        check("sat d1 finish4", d1_f4, 15);
        check("sat d0 finish2", d0_f2, 20);
        set_ins(8'd0, 8'd0, 8'd0, 8'd0);
        tick(5);
        ack_run();

        // Simultaneous finish on RUN edge 0.
        start_run();
        set_ins(8'd122, 8'd122, 8'd122, 8'd122);
        tick();
        check("sim d1 all_done", d1_all_done, 1);
        check("sim d1 cycle", d1_cycle, 0);
        check("sim d1 finish3", d1_f3, 0);
        check("sim d0 busy", d0_busy, 1);
        set_ins(8'd0, 8'd0, 8'd0, 8'd0);
        tick(5);
        check("sim d0 all_done", d0_all_done, 1);
        ack_run();

        // Sticky capture: ins1 toggles 122/0/122.
        start_run();
        for (int e = 0; e <= 4; e++) begin
            set_ins((e == 1 || e == 3) ? 8'd122 : 8'd0,
                    (e == 4) ? 8'd122 : 8'd0, (e == 4) ? 8'd122 : 8'd0,
                    (e == 4) ? 8'd122 : 8'd0);
            tick();
        end
        check("sticky finish1", d0_f1, 1);
        check("sticky finish2", d0_f2, 4);
        check("sticky cycle", d0_cycle, 4);
        set_ins(8'd0, 8'd0, 8'd0, 8'd0);
        tick(5);
        ack_run();

        // Randomized traffic checked by the model.
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            start    = ($urandom_range(0, 3) == 0);
            done_ack = ($urandom_range(0, 2) == 0);
            ins1 = ($urandom_range(0, 9) == 0) ? 8'd122 : 8'($urandom_range(0, 255));
            ins2 = ($urandom_range(0, 9) == 0) ? 8'd122 : 8'($urandom_range(0, 255));
            ins3 = ($urandom_range(0, 9) == 0) ? 8'd122 : 8'($urandom_range(0, 255));
            ins4 = ($urandom_range(0, 9) == 0) ? 8'd122 : 8'($urandom_range(0, 255));
            tick();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
